note_stream_tx: RTL and testbench

- Consumer of the note associator's output array. Snapshots the 12-slot Note array when the associator signals finished.
- Emits only the valid slots, in ascending slot order, as a valid/ready beat stream with slot index and end-of-frame marker.
- Feeds downstream colour/LED mapping logic that cannot take a 12-wide parallel bus.

---
 rtl/note_stream_tx.sv | 155 +++++++++++++++
 tb/tb_note_stream_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_stream_tx: snapshots the 12-slot note array on start and streams the  |
// | valid slots in ascending order over valid/ready. Optional feature macro:   |
// | NOTE_STREAM_TX_AMP_THRESHOLD_EN (adds minAmp amplitude filter).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module note_stream_tx #(
  parameter int N     = 16,
  parameter int NOTES = 12,
  parameter int FPF   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NOTES-1:0][2*N:0]      notes,
`ifdef NOTE_STREAM_TX_AMP_THRESHOLD_EN
  input  logic [N-1:0]                 minAmp,
`endif
  input  logic                         start,
  output logic                         busy,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [N-1:0]                 outPosition,
  output logic [N-1:0]                 outAmplitude,
  output logic [$clog2(NOTES)-1:0]     outIndex,
  output logic                         outLast,
  output logic                         frameDone,
  output logic [7:0]                   dropCount
);

  localparam int c_idx_w = $clog2(NOTES);
  localparam logic [NOTES-1:0] c_one = {{(NOTES-1){1'b0}}, 1'b1};

  // Position is fixed point with FPF fractional bits; it is passed through untouched.
  if (FPF > N) begin : g_fpf_check
    $error("FPF must not exceed N");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  state_t             r_state;
  logic [NOTES-1:0]   r_mask;
  logic [N-1:0]       r_pos [NOTES];
  logic [N-1:0]       r_amp [NOTES];

  logic [NOTES-1:0]   w_cap_mask;
  logic [NOTES-1:0]   w_rem;
  logic [NOTES-1:0]   w_sel_mask;
  logic [NOTES-1:0]   w_sel_rest;
  logic [c_idx_w-1:0] w_sel_idx;
  logic [N-1:0]       w_sel_pos;
  logic [N-1:0]       w_sel_amp;
  logic               w_hs;

  function automatic logic [c_idx_w-1:0] f_lowest(input logic [NOTES-1:0] m);
    f_lowest = '0;
    for (int i = NOTES - 1; i >= 0; i--) begin
      if (m[i]) f_lowest = c_idx_w'(i);
    end
  endfunction

  always_comb begin
    w_cap_mask = '0;
    for (int i = 0; i < NOTES; i++) begin
`ifdef NOTE_STREAM_TX_AMP_THRESHOLD_EN
      w_cap_mask[i] = notes[i][0] && (notes[i][N:1] >= minAmp);
`else
      w_cap_mask[i] = notes[i][0];
`endif
    end
  end

  // r_mask still contains the slot being presented; w_rem is what is left after it.
  assign w_hs       = outValid && outReady;
  assign w_rem      = r_mask & ~(c_one << outIndex);
  assign w_sel_mask = (r_state == ST_IDLE) ? w_cap_mask : w_rem;
  assign w_sel_idx  = f_lowest(w_sel_mask);
  assign w_sel_rest = w_sel_mask & ~(c_one << w_sel_idx);

  // The first beat of a frame comes straight from the inputs being captured.
  always_comb begin
    w_sel_pos = r_pos[w_sel_idx];
    w_sel_amp = r_amp[w_sel_idx];
    if (r_state == ST_IDLE) begin
      w_sel_pos = notes[w_sel_idx][2*N:N+1];
      w_sel_amp = notes[w_sel_idx][N:1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      busy         <= 1'b0;
      outValid     <= 1'b0;
      outPosition  <= '0;
      outAmplitude <= '0;
      outIndex     <= '0;
      outLast      <= 1'b0;
      frameDone    <= 1'b0;
      dropCount    <= '0;
      for (int i = 0; i < NOTES; i++) begin
        r_pos[i] <= '0;
        r_amp[i] <= '0;
      end
    end else begin
      frameDone <= 1'b0;
      if (start && (r_state == ST_SEND) && (dropCount != 8'hFF))
        dropCount <= dropCount + 8'd1;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NOTES; i++) begin
              r_pos[i] <= notes[i][2*N:N+1];
              r_amp[i] <= notes[i][N:1];
            end
            r_mask <= w_cap_mask;
            if (w_cap_mask != '0) begin
              r_state      <= ST_SEND;
              busy         <= 1'b1;
              outValid     <= 1'b1;
              outIndex     <= w_sel_idx;
              outPosition  <= w_sel_pos;
              outAmplitude <= w_sel_amp;
              outLast      <= (w_sel_rest == '0);
            end else begin
              frameDone <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            r_mask <= w_rem;
            if (w_rem == '0) begin
              r_state   <= ST_IDLE;
              busy      <= 1'b0;
              outValid  <= 1'b0;
              frameDone <= 1'b1;
            end else begin
              outIndex     <= w_sel_idx;
              outPosition  <= w_sel_pos;
              outAmplitude <= w_sel_amp;
              outLast      <= (w_sel_rest == '0);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_note_stream_tx: scoreboard bench for note_stream_tx.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_note_stream_tx;
  localparam int N     = 16;
  localparam int NOTES = 12;
  localparam int IW    = $clog2(NOTES);

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    outReady = 1'b0;
  logic [NOTES-1:0][2*N:0] notes;
`ifdef NOTE_STREAM_TX_AMP_THRESHOLD_EN
  logic [N-1:0]            minAmp = '0;
`endif
  logic                    busy, outValid, outLast, frameDone;
  logic [N-1:0]            outPosition, outAmplitude;
  logic [IW-1:0]           outIndex;
  logic [7:0]              dropCount;

  note_stream_tx #(.N(N), .NOTES(NOTES), .FPF(10)) dut (
    .clk(clk), .rst(rst), .notes(notes),
`ifdef NOTE_STREAM_TX_AMP_THRESHOLD_EN
    .minAmp(minAmp),
`endif
    .start(start), .busy(busy), .outValid(outValid), .outReady(outReady),
    .outPosition(outPosition), .outAmplitude(outAmplitude), .outIndex(outIndex),
    .outLast(outLast), .frameDone(frameDone), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [N-1:0]  pos;
    logic [N-1:0]  amp;
    logic          last;
  } beat_t;

  beat_t sbq[$];
  int total = 0;
  int bad = 0;
  int fd_due = 0;
  int busy_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: checks every presented beat against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("frameDone", 32'(frameDone), 32'(fd_due == 1));
      if (fd_due > 0) fd_due--;
      if (busy) busy_cycles++;
      if (outValid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got index %0d expected no beat", outIndex);
        end else begin
          chk("outIndex", 32'(outIndex), 32'(sbq[0].idx));
          chk("outPosition", 32'(outPosition), 32'(sbq[0].pos));
          chk("outAmplitude", 32'(outAmplitude), 32'(sbq[0].amp));
          chk("outLast", 32'(outLast), 32'(sbq[0].last));
          if (outReady) begin
            if (sbq[0].last) fd_due = 1;
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [2*N:0] mk(input int pos, input int amp, input logic v);
    return {16'(pos), 16'(amp), v};
  endfunction

  task automatic set_frame_a();
    for (int i = 0; i < NOTES; i++) notes[i] = {{(2*N){1'bx}}, 1'b0};
    notes[0]  = mk(555,   10000, 1'b1);
    notes[3]  = mk(7282,  10000, 1'b1);
    notes[4]  = mk(8212,  20000, 1'b1);
    notes[5]  = mk(11776, 30000, 1'b1);
    notes[11] = mk(24545, 15775, 1'b1);
  endtask

  task automatic push(input int idx, input int pos, input int amp, input logic last);
    beat_t b;
    b.idx = IW'(idx); b.pos = N'(pos); b.amp = N'(amp); b.last = last;
    sbq.push_back(b);
  endtask

  task automatic push_frame_a();
    push(0, 555, 10000, 1'b0);
    push(3, 7282, 10000, 1'b0);
    push(4, 8212, 20000, 1'b0);
    push(5, 11776, 30000, 1'b0);
    push(11, 24545, 15775, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy && sbq.size() == 0 && fd_due == 0) return;
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got pending=%0d expected 0", nm, sbq.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    for (int i = 0; i < NOTES; i++) notes[i] = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dropCount", 32'(dropCount), 32'd0);
    chk("rst_outLast", 32'(outLast), 32'd0);

    // Full-rate frame
    set_frame_a();
    outReady = 1'b1;
    @(posedge clk); #1;
    busy_cycles = 0;
    push_frame_a();
    pulse_start();
    wait_done("frame_a", 50);
    chk("busy_cycles", 32'(busy_cycles), 32'd5);

    // Stalled frame; inputs scrambled after capture
    pat = 4'b1001;
    set_frame_a();
    push_frame_a();
    pulse_start();
    for (int i = 0; i < NOTES; i++) notes[i] = mk(i * 1111 + 7, 60000 - i, 1'b1);
    for (int k = 0; k < 200; k++) begin
      if (!busy && sbq.size() == 0) break;
      outReady = pat[k % 4];
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    wait_done("stall", 20);

    // Empty frame with X data in invalid slots
    for (int i = 0; i < NOTES; i++) notes[i] = {{(2*N){1'bx}}, 1'b0};
    busy_cycles = 0;
    pulse_start();
    fd_due = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("empty_busy_cycles", 32'(busy_cycles), 32'd0);
    chk("empty_outValid", 32'(outValid), 32'd0);

    // Starts while busy are dropped
    set_frame_a();
    outReady = 1'b0;
    push_frame_a();
    pulse_start();
    repeat (3) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
    end
    chk("dropCount_3", 32'(dropCount), 32'd3);
    outReady = 1'b1;
    wait_done("drop3", 30);

    outReady = 1'b0;
    push_frame_a();
    start = 1'b1;
    repeat (301) @(posedge clk);
    #1;
    start = 1'b0;
    chk("dropCount_sat", 32'(dropCount), 32'd255);
    outReady = 1'b1;
    wait_done("drop_sat", 30);

    // Asynchronous reset in the middle of beat 2
    set_frame_a();
    push_frame_a();
    pulse_start();
    @(posedge clk);
    #2;
    rst = 1'b1;
    sbq.delete();
    fd_due = 0;
    #1;
    chk("arst_outValid", 32'(outValid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_outIndex", 32'(outIndex), 32'd0);
    chk("arst_outPosition", 32'(outPosition), 32'd0);
    chk("arst_dropCount", 32'(dropCount), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NOTES; i++) notes[i] = {{(2*N){1'bx}}, 1'b0};
    notes[7] = mk(1234, 4321, 1'b1);
    push(7, 1234, 4321, 1'b1);
    pulse_start();
    wait_done("slot7", 20);

`ifdef NOTE_STREAM_TX_AMP_THRESHOLD_EN
    set_frame_a();
    minAmp = 16'd15000;
    push(4, 8212, 20000, 1'b0);
    push(5, 11776, 30000, 1'b0);
    push(11, 24545, 15775, 1'b1);
    pulse_start();
    minAmp = 16'd0;
    wait_done("threshold", 30);
`endif

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
